// File: rtl/img_frame_ctrl_if.sv
// rtl/img_frame_ctrl_if.sv - UART-side byte, pixel-write and ACK signals of img_frame_ctrl
// master: host/UART side that drives bytes and TX ready; slave: the controller.
interface img_frame_ctrl_if #(
    parameter int CNT_W = 17
);
    logic [7:0]       i_data;
    logic             i_rx_done;
    logic             i_tx_ready;
    logic [7:0]       o_state;
    logic [7:0]       o_pix_data;
    logic             o_pix_we;
    logic [CNT_W-1:0] o_pix_addr;
    logic             o_img_done;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;

    modport master (
        output i_data, i_rx_done, i_tx_ready,
        input  o_state, o_pix_data, o_pix_we, o_pix_addr, o_img_done, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_data, i_rx_done, i_tx_ready,
        output o_state, o_pix_data, o_pix_we, o_pix_addr, o_img_done, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/img_frame_ctrl.sv
// rtl/img_frame_ctrl.sv - WAIT/TRANSPORT/DISPLAY/ERROR command sequencer with pixel stream and ACK
// Image bytes are counted internally; a stalled transfer times out into ERROR.
module img_frame_ctrl #(
    parameter int         IMG_BYTES   = 76800,
    parameter int         CNT_W       = 17,
    parameter int         TIMEOUT_CYC = 50_000_000,
    parameter int         TO_W        = 26,
    parameter logic [7:0] CMD_ADV     = 8'h5A,
    parameter logic [7:0] CMD_ABORT   = 8'hA0,
    parameter logic [7:0] ACK_BASE    = 8'hA0
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    img_frame_ctrl_if.slave   bus
);
    localparam logic [7:0] ST_WAIT      = 8'h01;
    localparam logic [7:0] ST_TRANSPORT = 8'h02;
    localparam logic [7:0] ST_DISPLAY   = 8'h03;
    localparam logic [7:0] ST_ERROR     = 8'h04;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic [7:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_idle;
    logic             r_img_done;
    logic             r_pix_we;
    logic [7:0]       r_pix_data;
    logic [CNT_W-1:0] r_pix_addr;
    logic             r_chg;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;

    logic [7:0]       w_next_state;
    logic             w_is_adv;
    logic             w_is_abort;
    logic             w_receiving;
    logic             w_wr;
    logic             w_timeout;
    logic             w_start;

    assign w_is_adv    = bus.i_rx_done && (bus.i_data == CMD_ADV);
    assign w_is_abort  = bus.i_rx_done && (bus.i_data == CMD_ABORT);
    // Image phase of TRANSPORT: every byte is data, no command decoding
    assign w_receiving = (r_state == ST_TRANSPORT) && !r_img_done;
    assign w_wr        = w_receiving && bus.i_rx_done;
    assign w_timeout   = w_receiving && !bus.i_rx_done && (r_idle == TO_LAST);
    assign w_start     = (r_state == ST_WAIT) && w_is_adv;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT: begin
                if (w_is_adv) w_next_state = ST_TRANSPORT;
            end
            ST_TRANSPORT: begin
                if (r_img_done) begin
                    if (w_is_adv)        w_next_state = ST_DISPLAY;
                    else if (w_is_abort) w_next_state = ST_WAIT;
                end else if (w_timeout) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_DISPLAY, ST_ERROR: begin
                if (w_is_adv || w_is_abort) w_next_state = ST_WAIT;
            end
            default: w_next_state = ST_WAIT;
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_WAIT;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_img_done <= 1'b0;
            r_pix_we   <= 1'b0;
            r_pix_data <= 8'h00;
            r_pix_addr <= '0;
        end else begin
            r_state  <= w_next_state;
            r_pix_we <= w_wr;
            if (w_start) begin
                r_cnt      <= '0;
                r_idle     <= '0;
                r_img_done <= 1'b0;
            end else if (w_wr) begin
                r_pix_data <= bus.i_data;
                r_pix_addr <= r_cnt;
                r_cnt      <= r_cnt + CNT_W'(1);
                r_idle     <= '0;
                if (r_cnt == LAST_IDX) r_img_done <= 1'b1;
            end else if (w_receiving && !w_timeout) begin
                r_idle <= r_idle + TO_W'(1);
            end
        end
    end

    // ACK is loaded one cycle after the state change, from the settled state register;
    // a fresh load takes priority over clearing on a transfer.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chg      <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_chg <= (w_next_state != r_state);
            if (r_chg) begin
                r_tx_data  <= ACK_BASE | r_state;
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid && bus.i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign bus.o_state    = r_state;
    assign bus.o_pix_we   = r_pix_we;
    assign bus.o_pix_data = r_pix_data;
    assign bus.o_pix_addr = r_pix_addr;
    assign bus.o_img_done = r_img_done;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_valid = r_tx_valid;
endmodule

// File: tb/tb_img_frame_ctrl.sv
// tb/tb_img_frame_ctrl.sv - vector table plus scoreboard bench for img_frame_ctrl
// Small image (4 bytes) and short timeout (8 cycles) keep corner cases quick.
module tb_img_frame_ctrl;
    localparam int CNT_W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    img_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();

    img_frame_ctrl #(
        .IMG_BYTES   (4),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (8),
        .TO_W        (4),
        .CMD_ADV     (8'h5A),
        .CMD_ABORT   (8'hA0),
        .ACK_BASE    (8'hA0)
    ) dut (
        .i_clk_sys (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [CNT_W+7:0] pix_q[$];
    logic [7:0]       ack_q[$];

    typedef struct {
        logic [7:0]       d;
        logic [7:0]       st;
        logic             we;
        logic [CNT_W-1:0] addr;
        logic             done;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_data    = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", 32'(bus.o_state), 32'h01);
        chk("rst_pix_we", 32'(bus.o_pix_we), 32'h0);
        chk("rst_pix_data", 32'(bus.o_pix_data), 32'h0);
        chk("rst_pix_addr", 32'(bus.o_pix_addr), 32'h0);
        chk("rst_img_done", 32'(bus.o_img_done), 32'h0);
        chk("rst_tx_data", 32'(bus.o_tx_data), 32'h0);
        chk("rst_tx_valid", 32'(bus.o_tx_valid), 32'h0);
    endtask

    // Scoreboard: pop expected writes / ACK transfers as the DUT produces them
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_pix_we) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected: got write addr %0d data %0h expected none",
                             bus.o_pix_addr, bus.o_pix_data);
                end else begin
                    logic [CNT_W+7:0] e;
                    e = pix_q.pop_front();
                    chk("pix_addr", 32'(bus.o_pix_addr), 32'(e[CNT_W+7:8]));
                    chk("pix_data", 32'(bus.o_pix_data), 32'(e[7:0]));
                end
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got transfer %0h expected none", bus.o_tx_data);
                end else begin
                    logic [7:0] a;
                    a = ack_q.pop_front();
                    chk("ack_data", 32'(bus.o_tx_data), 32'(a));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] prev_st;

        vt[0]  = '{8'h33, 8'h01, 1'b0, 17'd0, 1'b0};
        vt[1]  = '{8'h5A, 8'h02, 1'b0, 17'd0, 1'b0};
        vt[2]  = '{8'h11, 8'h02, 1'b1, 17'd0, 1'b0};
        vt[3]  = '{8'h5A, 8'h02, 1'b1, 17'd1, 1'b0};
        vt[4]  = '{8'hA0, 8'h02, 1'b1, 17'd2, 1'b0};
        vt[5]  = '{8'h22, 8'h02, 1'b1, 17'd3, 1'b1};
        vt[6]  = '{8'h33, 8'h02, 1'b0, 17'd0, 1'b1};
        vt[7]  = '{8'h5A, 8'h03, 1'b0, 17'd0, 1'b1};
        vt[8]  = '{8'h5A, 8'h01, 1'b0, 17'd0, 1'b1};
        vt[9]  = '{8'h5A, 8'h02, 1'b0, 17'd0, 1'b0};
        vt[10] = '{8'h44, 8'h02, 1'b1, 17'd0, 1'b0};
        vt[11] = '{8'h55, 8'h02, 1'b1, 17'd1, 1'b0};
        vt[12] = '{8'h66, 8'h02, 1'b1, 17'd2, 1'b0};
        vt[13] = '{8'h77, 8'h02, 1'b1, 17'd3, 1'b1};
        vt[14] = '{8'hA0, 8'h01, 1'b0, 17'd0, 1'b1};

        bus.i_data     = 8'h00;
        bus.i_rx_done  = 1'b0;
        bus.i_tx_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // First ACK handshake, then the timeout path
        ack_q.push_back(8'hA2);
        send(8'h5A);
        chk("adv_state", 32'(bus.o_state), 32'h02);
        chk("ack_not_yet", 32'(bus.o_tx_valid), 32'h0);
        tick();
        chk("ack_valid", 32'(bus.o_tx_valid), 32'h1);
        chk("ack_a2", 32'(bus.o_tx_data), 32'hA2);
        bus.i_tx_ready = 1'b1;
        tick();
        chk("ack_cleared", 32'(bus.o_tx_valid), 32'h0);

        pix_q.push_back({17'd0, 8'hC1});
        send(8'hC1);
        repeat (7) tick();
        pix_q.push_back({17'd1, 8'hC2});
        send(8'hC2);
        chk("to_race_state", 32'(bus.o_state), 32'h02);
        chk("to_race_we", 32'(bus.o_pix_we), 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_hold_state", 32'(bus.o_state), 32'h02);
        end
        ack_q.push_back(8'hA4);
        tick();
        chk("to_error_state", 32'(bus.o_state), 32'h04);
        send(8'h33);
        chk("err_ignore", 32'(bus.o_state), 32'h04);
        ack_q.push_back(8'hA1);
        send(8'h5A);
        chk("err_exit", 32'(bus.o_state), 32'h01);
        repeat (3) tick();

        // Reset mid-image
        ack_q.push_back(8'hA2);
        send(8'h5A);
        pix_q.push_back({17'd0, 8'hE1});
        send(8'hE1);
        pix_q.push_back({17'd1, 8'hE2});
        send(8'hE2);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst_n = 1'b1;
        tick();

        // Table: commands, image data equal to command codes, saturation, re-entry
        prev_st = 8'h01;
        for (int i = 0; i < 15; i++) begin
            if (vt[i].we) pix_q.push_back({vt[i].addr, vt[i].d});
            if (vt[i].st != prev_st) ack_q.push_back(8'hA0 | vt[i].st);
            prev_st = vt[i].st;
            send(vt[i].d);
            chk($sformatf("vec%0d_state", i), 32'(bus.o_state), 32'(vt[i].st));
            chk($sformatf("vec%0d_we", i), 32'(bus.o_pix_we), 32'(vt[i].we));
            chk($sformatf("vec%0d_done", i), 32'(bus.o_img_done), 32'(vt[i].done));
        end
        repeat (4) tick();

        // ACK overwrite while TX is not ready: only the newest code is sent
        bus.i_tx_ready = 1'b0;
        ack_q.push_back(8'hA3);
        send(8'h5A);
        for (int i = 0; i < 4; i++) begin
            pix_q.push_back({17'(i), 8'(8'h80 + i)});
            send(8'(8'h80 + i));
        end
        send(8'h5A);
        chk("hold_state", 32'(bus.o_state), 32'h03);
        tick();
        chk("hold_valid", 32'(bus.o_tx_valid), 32'h1);
        chk("hold_data", 32'(bus.o_tx_data), 32'hA3);
        bus.i_tx_ready = 1'b1;
        tick();
        chk("hold_cleared", 32'(bus.o_tx_valid), 32'h0);
        chk("hold_data_kept", 32'(bus.o_tx_data), 32'hA3);
        repeat (3) tick();

        ack_q.push_back(8'hA1);
        send(8'hA0);
        chk("disp_exit", 32'(bus.o_state), 32'h01);
        chk("disp_done_kept", 32'(bus.o_img_done), 32'h1);
        repeat (4) tick();

        chk("pix_q_empty", 32'(pix_q.size()), 32'h0);
        chk("ack_q_empty", 32'(ack_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/img_frame_ctrl.md
# img_frame_ctrl

Parametrised command/receive controller for the photo-frame UART path. It sequences WAIT → TRANSPORT → DISPLAY from host command bytes and counts image bytes into a pixel-write stream, so image-complete is generated internally rather than supplied from outside. It detects a stalled transfer with a timeout, entering an ERROR state, and acknowledges every state change to the host with a per-state byte over a valid/ready TX handshake. It sits between the UART receiver/transmitter and the frame buffer/display logic.

## Interface
- IMG_BYTES, 76800, bytes per image; must be ≥1 and ≤ 2^CNT_W − 1
- CNT_W, 17, byte counter / pixel address width
- TIMEOUT_CYC, 50_000_000, idle cycles tolerated in TRANSPORT before ERROR; must be ≥2
- TO_W, 26, timeout counter width; must hold TIMEOUT_CYC
- CMD_ADV, 8'h5A, advance command byte
- CMD_ABORT, 8'hA0, abort/return-to-WAIT command byte
- ACK_BASE, 8'hA0, ACK byte = ACK_BASE | state code
- i_clk_sys  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_data  in  8  received UART byte, valid when i_rx_done=1
- i_rx_done  in  1  single-cycle byte strobe; each high cycle is one byte
- i_tx_ready  in  1  UART TX can accept a byte
- o_state  out  8  state code: 8'h01 WAIT, 8'h02 TRANSPORT, 8'h03 DISPLAY, 8'h04 ERROR
- o_pix_data  out  8  image byte
- o_pix_we  out  1  one-cycle write strobe for o_pix_data
- o_pix_addr  out  CNT_W  byte index of o_pix_data, 0..IMG_BYTES−1
- o_img_done  out  1  high while all IMG_BYTES bytes of the current image have been received
- o_tx_data  out  8  ACK byte
- o_tx_valid  out  1  ACK valid; held until accepted

## Operation
- The state register drives o_state directly.
- WAIT:
  - CMD_ADV → TRANSPORT; clear the byte counter, the idle counter and o_img_done.
  - All other bytes are ignored.
- TRANSPORT, while count < IMG_BYTES:
  - Every byte is image data, including values equal to CMD_ADV or CMD_ABORT. No command is decoded.
  - Each byte produces o_pix_we=1, o_pix_data=byte, o_pix_addr=count; count then increments.
  - When count reaches IMG_BYTES, o_img_done=1. The counter saturates and further data is not written.
- TRANSPORT, after o_img_done=1:
  - CMD_ADV → DISPLAY; CMD_ABORT → WAIT; other bytes ignored, no write.
- TRANSPORT timeout:
  - The idle counter clears on every i_rx_done and increments otherwise. It runs only while o_img_done=0.
  - Reaching TIMEOUT_CYC−1 → ERROR.
  - Timeout and i_rx_done in the same cycle: the byte wins, is written, and the counter clears.
- DISPLAY: CMD_ADV or CMD_ABORT → WAIT. o_img_done stays 1 until the next WAIT → TRANSPORT transition.
- ERROR: CMD_ADV or CMD_ABORT → WAIT; other bytes ignored.
- ACK:
  - Every state change loads o_tx_data = ACK_BASE | new code (A1/A2/A3/A4) and sets o_tx_valid.
  - Transfer occurs on a cycle with o_tx_valid && i_tx_ready; o_tx_valid clears the next cycle unless a new change is loaded.
  - A change while an ACK is pending overwrites o_tx_data with the newer code (one-deep, newest wins); o_tx_valid stays 1.
  - A transfer and a new change in the same cycle: the new ACK is loaded and o_tx_valid stays 1.
  - o_tx_data holds its last value when idle.
- Reset (any time, including mid-image): state WAIT, counters 0, all outputs to reset values, pending ACK discarded. No ACK is sent for reset.

## Timing
- Reset values:
  - o_state=8'h01
  - o_pix_we=0, o_pix_data=0, o_pix_addr=0
  - o_img_done=0
  - o_tx_data=8'h00, o_tx_valid=0
- For a byte sampled (i_rx_done=1) at edge k:
  - o_state reflects the transition after edge k.
  - o_pix_we/o_pix_data/o_pix_addr are valid for exactly the cycle after edge k.
  - o_img_done rises after edge k when that byte is the last.
- ACK: o_tx_valid rises after edge k+1, one cycle after the state change.
- Back-to-back strobes on consecutive cycles are supported: one write per strobe, addresses consecutive.
- Timeout: the state enters ERROR TIMEOUT_CYC cycles after the last byte's edge.

## Test plan
- Reset, then CMD_ADV byte → o_state 01→02; next cycle o_tx_valid=1, o_tx_data=8'hA2; accepted when i_tx_ready=1, then o_tx_valid=0.
- IMG_BYTES=4: send 5A, then 11 5A A0 22 → four writes at addr 0..3 with data 11,5A,A0,22; o_img_done=1; state stays 02; then 5A → state 03, ACK A3.
- With o_img_done=1, send 33 → no write, state unchanged; then A0 → state 01, ACK A1.
- TIMEOUT_CYC=8, IMG_BYTES=4: send 5A, one data byte, then idle → state 04 eight cycles after that byte, ACK A4; then 5A → state 01.
- Hold i_tx_ready=0 over two state changes (02 then 03) → o_tx_valid stays 1, o_tx_data=A3; release ready → exactly one transfer.
- Assert i_rst_n=0 after two data bytes → all outputs at reset values immediately; after release, the counter restarts at addr 0 on the next 5A and data sequence.
